// File: rtl/hilo_multiplier.sv
// Hi/Lo multiply unit: iterative unsigned shift-add MULTU with MFHI/MFLO readback.
module hilo_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] Output,
  output logic             Busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH + 1;

  localparam logic [5:0] SIG_MULTU = 6'd25;
  localparam logic [5:0] SIG_MFHI  = 6'd16;
  localparam logic [5:0] SIG_MFLO  = 6'd18;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic             armed;
  logic             start;
  logic [CW-1:0]    counter;
  logic [PW-1:0]    product;
  logic [PW-1:0]    step;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // A new multiply needs Signal to have left MULTU since the last start
  assign start = (state == IDLE) && (Signal == SIG_MULTU) && armed;

  // One shift-add step: conditional add into the upper half with carry, then shift right
  assign sum  = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
  assign step = product[0] ? {sum, product[WIDTH-1:0]} : product;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = MUL;
      MUL:     if (counter == LAST_ITER) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Rearm flag: cleared on start, set whenever Signal is not MULTU
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   armed <= 1'b1;
    else if (start)              armed <= 1'b0;
    else if (Signal != SIG_MULTU) armed <= 1'b1;
  end

  // Multiply datapath: operand latch, iteration counter and product/carry register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      product <= '0;
      counter <= '0;
    end else if (start) begin
      mcand   <= dataA;
      product <= {(WIDTH + 1)'(0), dataB};
      counter <= '0;
    end else if (state == MUL) begin
      product <= step >> 1;
      counter <= counter + CW'(1);
    end
  end

  // Hi/Lo commit, only in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == DONE) begin
      hi <= product[2*WIDTH-1:WIDTH];
      lo <= product[WIDTH-1:0];
    end
  end

  // MFHI/MFLO readback mux
  always_comb begin
    Output = '0;
    if (Signal == SIG_MFHI)      Output = hi;
    else if (Signal == SIG_MFLO) Output = lo;
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_hilo_multiplier.sv
// Directed self-checking bench for hilo_multiplier (WIDTH = 32).
module tb_hilo_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] Output;
  logic        Busy;

  int n_checks = 0;
  int n_fail   = 0;

  hilo_multiplier #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
    .Output (Output),
    .Busy   (Busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; Signal = 6'd16; dataA = '0; dataB = '0;
    #3;
    n_checks++;
    if (Output !== 32'd0) begin n_fail++; $display("FAIL reset_mfhi: got %h want %h", Output, 32'd0); end
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    Signal = 6'd18;
    #1;
    n_checks++;
    if (Output !== 32'd0) begin n_fail++; $display("FAIL reset_mflo: got %h want %h", Output, 32'd0); end
    tick();
    tick();
    reset = 1'b0;
    Signal = 6'd0;
  endtask

  // Full MULTU: 35-edge window, Busy must be high on exactly 33 of them, then read Hi/Lo
  task automatic test_multu(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input string name);
    int busy_cnt;
    busy_cnt = 0;
    dataA = a; dataB = b; Signal = 6'd25;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (Busy === 1'b1) busy_cnt++;
    end
    n_checks++;
    if (busy_cnt != 33) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d want 33", name, busy_cnt); end
    Signal = 6'd16;
    #1;
    n_checks++;
    if (Output !== ehi) begin n_fail++; $display("FAIL %s_hi: got %h want %h", name, Output, ehi); end
    Signal = 6'd18;
    #1;
    n_checks++;
    if (Output !== elo) begin n_fail++; $display("FAIL %s_lo: got %h want %h", name, Output, elo); end
    tick();
  endtask

  // Unassigned codes must read 0 and leave Hi/Lo untouched
  task automatic test_noop(input logic [31:0] ehi, input logic [31:0] elo);
    dataA = 32'h1234_5678; dataB = 32'h9abc_def0;
    Signal = 6'd5;
    #1;
    n_checks++;
    if (Output !== 32'd0) begin n_fail++; $display("FAIL noop_output: got %h want 0", Output); end
    tick(); tick(); tick();
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL noop_busy: got %b want 0", Busy); end
    Signal = 6'd16;
    #1;
    n_checks++;
    if (Output !== ehi) begin n_fail++; $display("FAIL noop_hi: got %h want %h", Output, ehi); end
    Signal = 6'd18;
    #1;
    n_checks++;
    if (Output !== elo) begin n_fail++; $display("FAIL noop_lo: got %h want %h", Output, elo); end
    tick();
  endtask

  // Holding MULTU for 40 edges gives one multiply; a single non-25 edge rearms
  task automatic test_rearm();
    int busy_cnt;
    busy_cnt = 0;
    dataA = 32'd9; dataB = 32'd9; Signal = 6'd25;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Busy === 1'b1) busy_cnt++;
    end
    n_checks++;
    if (busy_cnt != 33) begin n_fail++; $display("FAIL rearm_single_busy: got %0d want 33", busy_cnt); end
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL rearm_idle_after: got %b want 0", Busy); end
    Signal = 6'd0;
    tick();
    dataA = 32'd11; dataB = 32'd13; Signal = 6'd25;
    tick();
    n_checks++;
    if (Busy !== 1'b1) begin n_fail++; $display("FAIL rearm_restart: got %b want 1", Busy); end
    for (int i = 0; i < 34; i++) tick();
    Signal = 6'd18;
    #1;
    n_checks++;
    if (Output !== 32'd143) begin n_fail++; $display("FAIL rearm_second_lo: got %0d want 143", Output); end
    tick();
  endtask

  // Reset at iteration 10 discards the operation; the next multiply is clean
  task automatic test_reset_mid();
    dataA = 32'd100000; dataB = 32'd100000; Signal = 6'd25;
    tick();
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (Busy !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_busy: got %b want 1", Busy); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", Busy); end
    Signal = 6'd16;
    #1;
    n_checks++;
    if (Output !== 32'd0) begin n_fail++; $display("FAIL midreset_hi: got %h want 0", Output); end
    Signal = 6'd18;
    #1;
    n_checks++;
    if (Output !== 32'd0) begin n_fail++; $display("FAIL midreset_lo: got %h want 0", Output); end
    tick();
    reset = 1'b0;
    test_multu(32'd7, 32'd6, 32'd0, 32'd42, "mul7x6");
  endtask

  // MFLO during a multiply returns the old Lo; operand changes mid-MUL are ignored
  task automatic test_read_while_busy();
    int waited;
    dataA = 32'd2; dataB = 32'd2; Signal = 6'd25;
    tick();
    tick(); tick(); tick();
    dataA = 32'hFFFF_FFFF; dataB = 32'hFFFF_FFFF;
    Signal = 6'd18;
    #1;
    n_checks++;
    if (Output !== 32'd15) begin n_fail++; $display("FAIL busy_read_lo: got %0d want 15", Output); end
    n_checks++;
    if (Busy !== 1'b1) begin n_fail++; $display("FAIL busy_read_busy: got %b want 1", Busy); end
    waited = 0;
    while (Busy === 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL busy_read_timeout: busy still %b after %0d edges", Busy, waited); end
    #1;
    n_checks++;
    if (Output !== 32'd4) begin n_fail++; $display("FAIL busy_read_final_lo: got %0d want 4", Output); end
    Signal = 6'd16;
    #1;
    n_checks++;
    if (Output !== 32'd0) begin n_fail++; $display("FAIL busy_read_final_hi: got %0d want 0", Output); end
    tick();
  endtask

  initial begin
    test_reset();
    tick();
    test_multu(32'd3, 32'd5, 32'd0, 32'd15, "mul3x5");
    test_multu(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "mulmax");
    test_multu(32'h8000_0000, 32'd2, 32'd1, 32'd0, "mulmsb");
    test_noop(32'd1, 32'd0);
    test_rearm();
    test_reset_mid();
    test_multu(32'd3, 32'd5, 32'd0, 32'd15, "mul3x5b");
    test_read_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_multiplier.md
HILO_MULTIPLIER -- requirements
Module: hilo_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand width and Hi/Lo register width.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port dataA  input  WIDTH  unsigned multiplicand.
REQ-005 The block SHALL have port dataB  input  WIDTH  unsigned multiplier.
REQ-006 The block SHALL have port Signal  input  6  function code: 25 MULTU, 16 MFHI, 18 MFLO; all other codes are no-ops.
REQ-007 The block SHALL have port Output  output  WIDTH  result of MFHI/MFLO.
REQ-008 The block SHALL have port Busy  output  1  high while a multiply is in progress.

Function
REQ-009 States SHALL be IDLE, MUL and DONE; the state SHALL be IDLE after reset.
REQ-010 An internal armed flag SHALL be set by reset and set on any edge where Signal != 25; it SHALL be cleared on start.
REQ-011 Start SHALL occur on a rising edge in IDLE with Signal == 25 and armed == 1: latch dataA/dataB, clear the 2*WIDTH+1 product/carry register's upper half, load the multiplier into the lower half, zero the iteration counter, and go to MUL.
REQ-012 Holding Signal at 25 after completion SHALL NOT start another multiply; Signal must leave 25 for at least one edge first.
REQ-013 MUL SHALL run exactly WIDTH cycles of shift-add: if product LSB = 1, add the multiplicand to the upper WIDTH bits with a (WIDTH+1)-bit carry; then shift the whole register right one bit.
REQ-014 After iteration WIDTH-1 the state SHALL go to DONE; DONE SHALL last one cycle, write Hi = product[2W-1:W] and Lo = product[W-1:0], then go to IDLE.
REQ-015 Latency SHALL be WIDTH+1 cycles from the start edge to the Hi/Lo update edge (33 cycles for WIDTH=32); this fits within the 35-cycle MULTU window the bench drives.
REQ-016 Busy SHALL be 1 in MUL and DONE and 0 in IDLE; it SHALL be decoded from registered state only.
REQ-017 Hi/Lo SHALL change only in DONE or on reset; dataA/dataB changes during MUL SHALL NOT affect the result.
REQ-018 Output SHALL be combinational: Hi when Signal == 16, Lo when Signal == 18, otherwise 0.
REQ-019 MFHI/MFLO issued while Busy SHALL return the previously committed Hi/Lo and SHALL NOT stall or abort the multiply.
REQ-020 Arithmetic SHALL be unsigned modulo 2^(2*WIDTH); no overflow flag SHALL be produced.
REQ-021 Codes other than 25, 16 and 18 SHALL leave all state unchanged except the armed flag.

Reset
REQ-022 Reset SHALL immediately force state IDLE, counter 0, Hi 0, Lo 0, product register 0, armed 1 and Busy 0, independent of clk.
REQ-023 Reset asserted mid-MUL SHALL discard the operation; no partial result SHALL reach Hi/Lo.
REQ-024 The first rising edge after reset deasserts SHALL be able to start a multiply if Signal == 25.

Verification
REQ-025 Reset: assert reset, Signal=16 then 18 -> Output 0 both, Busy 0.
REQ-026 MULTU 3x5: Signal=25 for 35 cycles -> Busy high for exactly 33 cycles; then MFHI -> 0, MFLO -> 15.
REQ-027 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> MFHI 0xFFFFFFFE, MFLO 0x00000001; then 0x80000000 x 2 -> Hi 1, Lo 0.
REQ-028 Rearm: Signal held at 25 for 40 cycles -> exactly one multiply (Busy stays 0 after cycle 33); Signal=0 for one cycle then 25 -> second multiply starts.
REQ-029 Reset at iteration 10 of 100000 x 100000 -> Busy 0 immediately, MFHI/MFLO 0; then MULTU 7x6 -> Lo 42, Hi 0.
REQ-030 During MULTU 2x2 after a committed 3x5: Signal switched to 18 mid-MUL -> Output 15; after completion MFLO -> 4.
